// File: rtl/clock_set_pkg.sv
// rtl/clock_set_pkg.sv - shared field encoding and default timing constants for clock_set_ctrl
package clock_set_pkg;

    localparam int FIELD_W = 3;

    // The state code doubles as the set_field value seen by the display.
    typedef enum logic [FIELD_W-1:0] {
        ST_RUN   = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } field_e;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_TIMEOUT_CYC  = 64;
    localparam int DEF_BLINK_HALF   = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stable-count debouncer for one raw button
module btn_debounce
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
)(
    input  logic clk,
    input  logic rst_p,
    input  logic btn,
    output logic deb
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive cycles of disagreement; only a full run of them moves the level.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync_2;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - front-panel set-mode controller; CLOCK_SET_BLINK_EN adds field blinking
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
`ifdef CLOCK_SET_BLINK_EN
    ,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
`endif
)(
    input  logic               clk,
    input  logic               rst_p,
    input  logic               btn_mode,
    input  logic               btn_inc,
    output logic               pause,
    output logic               switch_second,
    output logic               switch_minute,
    output logic               switch_hour,
    output logic               switch_day,
    output logic               switch_month,
    output logic               switch_year,
    output logic [FIELD_W-1:0] set_field,
    output logic               blink_on
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic            deb_mode;
    logic            deb_inc;
    logic            deb_mode_d;
    logic            mode_press;
    field_e          state;
    field_e          state_next;
    logic [TO_W-1:0] to_cnt;
    logic            to_expire;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_mode (
        .clk   (clk),
        .rst_p (rst_p),
        .btn   (btn_mode),
        .deb   (deb_mode)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb_inc (
        .clk   (clk),
        .rst_p (rst_p),
        .btn   (btn_inc),
        .deb   (deb_inc)
    );

    // One-cycle MODE pulse on a debounced rising edge; releases are ignored.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            deb_mode_d <= 1'b0;
            mode_press <= 1'b0;
        end else begin
            deb_mode_d <= deb_mode;
            mode_press <= deb_mode & ~deb_mode_d;
        end
    end

    assign to_expire = (state != ST_RUN) && (to_cnt == TO_LAST);

    // Field-select state register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Walk the fields on each MODE press; an expiring timeout overrides a coincident press.
    always_comb begin
        state_next = state;
        if (to_expire) begin
            state_next = ST_RUN;
        end else if (mode_press) begin
            case (state)
                ST_RUN:   state_next = ST_SEC;
                ST_SEC:   state_next = ST_MIN;
                ST_MIN:   state_next = ST_HOUR;
                ST_HOUR:  state_next = ST_DAY;
                ST_DAY:   state_next = ST_MONTH;
                ST_MONTH: state_next = ST_YEAR;
                ST_YEAR:  state_next = ST_RUN;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    // Idle timer: any button activity restarts it, RUN holds it at zero.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            to_cnt <= '0;
        end else if ((state == ST_RUN) || to_expire || mode_press || deb_inc) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Outputs decode only registered state and the debounced INC level, so they never glitch.
    always_comb begin
        set_field     = state;
        pause         = (state != ST_RUN);
        switch_second = 1'b0;
        switch_minute = 1'b0;
        switch_hour   = 1'b0;
        switch_day    = 1'b0;
        switch_month  = 1'b0;
        switch_year   = 1'b0;
        case (state)
            ST_SEC:   switch_second = deb_inc;
            ST_MIN:   switch_minute = deb_inc;
            ST_HOUR:  switch_hour   = deb_inc;
            ST_DAY:   switch_day    = deb_inc;
            ST_MONTH: switch_month  = deb_inc;
            ST_YEAR:  switch_year   = deb_inc;
            default:  ;
        endcase
    end

`ifdef CLOCK_SET_BLINK_EN
    localparam int BL_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;

    // Blink phase restarts lit on every field change and stays parked while in RUN.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if ((state == ST_RUN) || (state_next != state)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BL_W'(1);
        end
    end

    assign blink_on = blink_phase | deb_inc | (state == ST_RUN);
`else
    assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - randomized self-checking bench for clock_set_ctrl against a behavioural model
module tb_clock_set_ctrl;

    localparam int D  = 4;
    localparam int TO = 64;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst_p = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       pause;
    logic       switch_second, switch_minute, switch_hour;
    logic       switch_day, switch_month, switch_year;
    logic [2:0] set_field;
    logic       blink_on;

    int total = 0;
    int bad = 0;

    clock_set_ctrl #(
        .DEBOUNCE_CYC (D),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk           (clk),
        .rst_p         (rst_p),
        .btn_mode      (btn_mode),
        .btn_inc       (btn_inc),
        .pause         (pause),
        .switch_second (switch_second),
        .switch_minute (switch_minute),
        .switch_hour   (switch_hour),
        .switch_day    (switch_day),
        .switch_month  (switch_month),
        .switch_year   (switch_year),
        .set_field     (set_field),
        .blink_on      (blink_on)
    );

    always #5 clk = ~clk;

    logic [10:0] dut_vec;
    assign dut_vec = {set_field, pause, switch_year, switch_month, switch_day,
                      switch_hour, switch_minute, switch_second, blink_on};

    localparam logic [10:0] RESET_VEC = 11'b000_0_000000_1;

    // Behavioural model: raw sample history, debounced levels, field index and idle count.
    bit q_mode[$];
    bit q_inc[$];
    bit m_deb_mode, m_deb_mode_prev, m_deb_inc, m_press;
    int m_state, m_idle, m_since;

    task automatic model_clear();
        q_mode.delete();
        q_inc.delete();
        m_deb_mode = 0; m_deb_mode_prev = 0; m_deb_inc = 0; m_press = 0;
        m_state = 0; m_idle = 0; m_since = 0;
    endtask

    // A debounced level flips when the last D synchronised samples (raw delayed 2 edges) all differ from it.
    function automatic bit next_deb(input bit cur, input bit q[$]);
        bit all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
            int idx = q.size() - 3 - k;
            bit v = (idx >= 0) ? q[idx] : 1'b0;
            if (v == cur) all_diff = 1'b0;
        end
        return all_diff ? ~cur : cur;
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [5:0] sw = '0;
        logic blink = 1'b1;
        if (m_state != 0 && m_deb_inc) sw[m_state-1] = 1'b1;
`ifdef CLOCK_SET_BLINK_EN
        blink = (m_state == 0) || m_deb_inc || (((m_since / BH) % 2) == 0);
`endif
        return {3'(m_state), (m_state != 0), sw, blink};
    endfunction

    // Drive one cycle of buttons (starting at a negedge), advance the model at the posedge, end at the next negedge.
    task automatic tick(input bit m, input bit i);
        bit n_dm, n_di, n_pr;
        int n_st, n_idle;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        q_mode.push_back(m);
        q_inc.push_back(i);
        if (q_mode.size() > 16) void'(q_mode.pop_front());
        if (q_inc.size() > 16) void'(q_inc.pop_front());
        n_dm = next_deb(m_deb_mode, q_mode);
        n_di = next_deb(m_deb_inc, q_inc);
        n_pr = m_deb_mode && !m_deb_mode_prev;
        n_st = m_state;
        n_idle = m_idle;
        if (m_state == 0) begin
            n_idle = 0;
            if (m_press) n_st = 1;
        end else if (m_idle == TO - 1) begin
            n_st = 0;
            n_idle = 0;
        end else begin
            n_idle = (m_press || m_deb_inc) ? 0 : m_idle + 1;
            if (m_press) n_st = (m_state + 1) % 7;
        end
        m_since = (n_st != m_state) ? 0 : m_since + 1;
        m_deb_mode_prev = m_deb_mode;
        m_deb_mode = n_dm;
        m_deb_inc = n_di;
        m_press = n_pr;
        m_state = n_st;
        m_idle = n_idle;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_p = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        rst_p = 1'b0;
        model_clear();
    endtask

    task automatic press_mode();
        repeat (8) tick(1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_p = 1'b1;
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        if (dut_vec !== RESET_VEC) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec, RESET_VEC);
        end
        total++;
        btn_inc = 1'b0;
        rst_p = 1'b0;
        model_clear();
        for (int n = 0; n < 4; n++) begin
            tick(1'b0, 1'b0);
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_idle n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
    endtask

    task automatic test_bounce();
        bit seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int first = -1;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            tick(seq[n], 1'b0);
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL bounce_model n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
        // The last '1' of the bounce is tick 0 of the stable level.
        for (int n = 1; n <= 20; n++) begin
            tick(1'b1, 1'b0);
            if (set_field == 3'd1 && first < 0) first = n;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL bounce_hold n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
        if (first !== D + 3) begin
            bad++; $display("FAIL bounce_latency got=%0d exp=%0d", first, D + 3);
        end
        total++;
        repeat (10) tick(1'b0, 1'b0);
        if ({set_field, pause} !== {3'd1, 1'b1}) begin
            bad++; $display("FAIL bounce_single_press got=%0d/%b exp=1/1", set_field, pause);
        end
        total++;
    endtask

    task automatic test_full_cycle();
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            press_mode();
            if (set_field !== 3'(k % 7) || pause !== (k % 7 != 0)) begin
                bad++; $display("FAIL full_cycle k=%0d got=%0d/%b exp=%0d/%b", k, set_field, pause, k % 7, (k % 7 != 0));
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL full_cycle_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
            end
            total++;
        end
    endtask

    task automatic test_inc_hold();
        int hi = 0;
        int first = -1;
        bit glitch_seen = 1'b0;
        do_reset();
        repeat (3) press_mode();
        for (int n = 0; n < 35; n++) begin
            tick(1'b0, n < 20);
            if (switch_hour) begin
                hi++;
                if (first < 0) first = n;
            end
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL inc_hold_model n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
        if (hi !== 20 || first !== D + 1) begin
            bad++; $display("FAIL inc_hold_window got=%0d@%0d exp=20@%0d", hi, first, D + 1);
        end
        total++;
        for (int n = 0; n < 12; n++) begin
            tick(1'b0, n < 2);
            if (switch_hour) glitch_seen = 1'b1;
        end
        if (glitch_seen !== 1'b0) begin
            bad++; $display("FAIL inc_glitch got=%b exp=0", glitch_seen);
        end
        total++;
        // MODE pressed while INC held: the switch moves to the next field.
        for (int n = 0; n < 20; n++) begin
            tick(n >= 8, 1'b1);
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL inc_mode_model n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
        if ({switch_day, switch_hour} !== 2'b10) begin
            bad++; $display("FAIL inc_mode_handover got=%b exp=10", {switch_day, switch_hour});
        end
        total++;
        repeat (10) tick(1'b0, 1'b0);
    endtask

    task automatic enter_min();
        int n = 0;
        press_mode();
        while (set_field != 3'd2 && n < 20) begin
            tick(1'b1, 1'b0);
            n++;
        end
        if (set_field !== 3'd2) begin
            bad++; $display("FAIL enter_min got=%0d exp=2", set_field);
        end
        total++;
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        enter_min();
        while (set_field != 3'd0 && n < 200) begin
            tick(1'b0, 1'b0);
            n++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL timeout_model n=%0d got=%b exp=%b", n, dut_vec, exp_vec());
            end
            total++;
        end
        if (n !== TO) begin
            bad++; $display("FAIL timeout_len got=%0d exp=%0d", n, TO);
        end
        total++;
        do_reset();
        enter_min();
        repeat (100) tick(1'b0, 1'b1);
        if (set_field !== 3'd2 || switch_minute !== 1'b1) begin
            bad++; $display("FAIL timeout_inc_hold got=%0d/%b exp=2/1", set_field, switch_minute);
        end
        total++;
        repeat (10) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_midop();
        int n = 0;
        do_reset();
        repeat (4) press_mode();
        while (!switch_day && n < 12) begin
            tick(1'b0, 1'b1);
            n++;
        end
        if (switch_day !== 1'b1) begin
            bad++; $display("FAIL midop_setup got=%b exp=1", switch_day);
        end
        total++;
        #2;
        rst_p = 1'b1;
        #1;
        if (dut_vec !== RESET_VEC) begin
            bad++; $display("FAIL midop_async_reset got=%b exp=%b", dut_vec, RESET_VEC);
        end
        total++;
        btn_inc = 1'b0;
        @(negedge clk);
        rst_p = 1'b0;
        model_clear();
    endtask

`ifdef CLOCK_SET_BLINK_EN
    task automatic test_blink();
        int n = 0;
        do_reset();
        while (set_field != 3'd1 && n < 20) begin
            tick(1'b1, 1'b0);
            n++;
        end
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 1'b0);
            if (blink_on !== (((k / BH) % 2) == 0)) begin
                bad++; $display("FAIL blink_toggle k=%0d got=%b", k, blink_on);
            end
            total++;
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b1);
            if (k >= D + 1 && blink_on !== 1'b1) begin
                bad++; $display("FAIL blink_inc_held k=%0d got=%b exp=1", k, blink_on);
            end
            total++;
        end
        repeat (10) tick(1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        int ticks = 0;
        do_reset();
        while (ticks < 2500) begin
            bit m = 1'($urandom_range(0, 1));
            bit i = ($urandom_range(0, 2) == 0);
            int len = $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) begin
                m = 1'b0; i = 1'b0; len = $urandom_range(60, 90);
            end
            for (int n = 0; n < len; n++) begin
                tick(m, i);
                ticks++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL random t=%0d got=%b exp=%b", ticks, dut_vec, exp_vec());
                end
                total++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_bounce();
        test_full_cycle();
        test_inc_hold();
        test_timeout();
        test_reset_midop();
`ifdef CLOCK_SET_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
